// File: rtl/sswfmcw_chirp_seq.sv
// sswfmcw_chirp_seq: chirp sequencer with shadowed config, sweep accumulator and TX gating
module sswfmcw_chirp_seq #(
    parameter int C_ADD_MIN    = 13631,
    parameter int C_ADD_MAX    = 14331,
    parameter int C_STEP       = 1,
    parameter int C_BLANK_LEN  = 2867200,
    parameter int C_BURST      = 0,
    parameter int C_AUTO_START = 1
) (
    input  logic        CK_i,
    input  logic        XARST_i,
    input  logic        START_i,
    input  logic        STOP_i,
    input  logic        CFG_WE_i,
    input  logic [2:0]  CFG_ADDRs_i,
    input  logic [23:0] CFG_DATs_i,
    output logic [13:0] FREQ_ADDs_o,
    output logic        TX_EN_o,
    output logic        CHIRP_START_o,
    output logic        FRAME_DONE_o,
    output logic        BUSY_o,
    output logic [7:0]  CHIRP_IDXs_o,
    output logic        CFG_ERR_o
);
    typedef enum logic [1:0] {IDLE, SWEEP, BLANK} state_t;
    state_t      state, state_nx;
    logic [13:0] s_min, s_max, a_min, a_max;
    logic [11:0] s_step, a_step, step_e;
    logic [23:0] s_blank, a_blank, cnt, cnt_nx;
    logic [7:0]  s_burst, a_burst, idx_nx;
    logic [25:0] acc, acc_nx;
    logic        rel, auto_done, auto_req, go, ok;
    logic        tx_nx, cs_nx, fd_nx, err_nx;

    assign step_e      = (a_step == 12'd0) ? 12'd1 : a_step;
    assign auto_req    = (C_AUTO_START != 0) && rel && !auto_done;
    assign go          = (state == IDLE) && !STOP_i && (START_i || auto_req);
    assign ok          = s_min < s_max;
    assign FREQ_ADDs_o = acc[25:12];

    // staging bank writes; auto-start request lives for the first clock after reset release
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            s_min     <= 14'(C_ADD_MIN);
            s_max     <= 14'(C_ADD_MAX);
            s_step    <= 12'(C_STEP);
            s_blank   <= 24'(C_BLANK_LEN);
            s_burst   <= 8'(C_BURST);
            rel       <= 1'b0;
            auto_done <= 1'b0;
        end else begin
            s_min     <= (CFG_WE_i && CFG_ADDRs_i == 3'd0) ? CFG_DATs_i[13:0] : s_min;
            s_max     <= (CFG_WE_i && CFG_ADDRs_i == 3'd1) ? CFG_DATs_i[13:0] : s_max;
            s_step    <= (CFG_WE_i && CFG_ADDRs_i == 3'd2) ? CFG_DATs_i[11:0] : s_step;
            s_blank   <= (CFG_WE_i && CFG_ADDRs_i == 3'd3) ? CFG_DATs_i : s_blank;
            s_burst   <= (CFG_WE_i && CFG_ADDRs_i == 3'd4) ? CFG_DATs_i[7:0] : s_burst;
            rel       <= 1'b1;
            auto_done <= auto_done | auto_req;
        end
    end

    // active bank takes the pre-write staging values on an accepted start
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            a_min   <= 14'(C_ADD_MIN);
            a_max   <= 14'(C_ADD_MAX);
            a_step  <= 12'(C_STEP);
            a_blank <= 24'(C_BLANK_LEN);
            a_burst <= 8'(C_BURST);
        end else if (go && ok) begin
            a_min   <= s_min;
            a_max   <= s_max;
            a_step  <= s_step;
            a_blank <= s_blank;
            a_burst <= s_burst;
        end
    end

    // next state, accumulator, counters and pulse outputs
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        idx_nx   = CHIRP_IDXs_o;
        cs_nx    = 1'b0;
        fd_nx    = 1'b0;
        err_nx   = 1'b0;
        if (STOP_i) begin
            state_nx = IDLE;
            acc_nx   = {a_min, 12'h0};
        end else begin
            case (state)
                IDLE: begin
                    if (go && ok) begin
                        state_nx = SWEEP;
                        acc_nx   = {s_min, 12'h0};
                        idx_nx   = 8'd0;
                        cs_nx    = 1'b1;
                    end
                    err_nx = go && !ok;
                end
                SWEEP: begin
                    if (acc >= {a_max, 12'h0}) begin
                        state_nx = BLANK;
                        acc_nx   = {a_min, 12'h0};
                        cnt_nx   = (a_blank == 24'd0) ? 24'd0 : a_blank - 24'd1;
                    end else begin
                        acc_nx = acc + {14'h0, step_e};
                    end
                end
                BLANK: begin
                    cnt_nx = cnt - 24'd1;
                    if (cnt == 24'd0) begin
                        if (a_burst == 8'd0 || {1'b0, CHIRP_IDXs_o} + 9'd1 < {1'b0, a_burst}) begin
                            state_nx = SWEEP;
                            idx_nx   = CHIRP_IDXs_o + 8'd1;
                            cs_nx    = 1'b1;
                        end else begin
                            state_nx = IDLE;
                            fd_nx    = 1'b1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        tx_nx = state_nx == SWEEP;
    end

    // state register and registered outputs
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state         <= IDLE;
            acc           <= {14'(C_ADD_MIN), 12'h0};
            cnt           <= 24'd0;
            CHIRP_IDXs_o  <= 8'd0;
            TX_EN_o       <= 1'b0;
            CHIRP_START_o <= 1'b0;
            FRAME_DONE_o  <= 1'b0;
            BUSY_o        <= 1'b0;
            CFG_ERR_o     <= 1'b0;
        end else begin
            state         <= state_nx;
            acc           <= acc_nx;
            cnt           <= cnt_nx;
            CHIRP_IDXs_o  <= idx_nx;
            TX_EN_o       <= tx_nx;
            CHIRP_START_o <= cs_nx;
            FRAME_DONE_o  <= fd_nx;
            BUSY_o        <= state_nx != IDLE;
            CFG_ERR_o     <= err_nx;
        end
    end
endmodule
